// File: rtl/vga_timing_gen_if.sv
// Video timing bus from the timing source to the overlay and draw stages.
// The source drives it; every later stage only samples and re-registers it.
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport master (
        output hcount, vcount, hsync, vsync,
        output hblnk, vblnk, rgb
    );

    modport slave (
        input hcount, vcount, hsync, vsync,
        input hblnk, vblnk, rgb
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Raster timing source: pixel/line counters, sync and blanking flags,
// a start-of-frame strobe and a frame counter, all registered together.
module vga_timing_gen #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 128,
    parameter int H_BP     = 88,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 23,
    parameter int SYNC_POL = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    vga_if.master       vga_out,
    output logic        sof,
    output logic [15:0] frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS  = 11'(H_ACTIVE);
    localparam logic [10:0] V_VIS  = 11'(V_ACTIVE);
    localparam logic [10:0] HS_LO  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_HI  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [10:0] VS_LO  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_HI  = 11'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic        ACT    = (SYNC_POL != 0);

    if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_size_chk
        $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 11-bit counters");
    end

    logic [10:0] h_q, v_q;
    logic [10:0] h_nxt, v_nxt;
    logic        hs_q, vs_q, hb_q, vb_q;
    logic        wrap;
    logic        hs_on, vs_on;

    always_comb begin
        h_nxt = h_q + 11'd1;
        v_nxt = v_q;
        wrap  = 1'b0;
        if (h_q == H_LAST) begin
            h_nxt = '0;
            if (v_q == V_LAST) begin
                v_nxt = '0;
                wrap  = 1'b1;
            end else begin
                v_nxt = v_q + 11'd1;
            end
        end
    end

    // Flags come from the next count so they land on the same edge as it.
    assign hs_on = (h_nxt >= HS_LO) && (h_nxt <= HS_HI);
    assign vs_on = (v_nxt >= VS_LO) && (v_nxt <= VS_HI);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q       <= '0;
            v_q       <= '0;
            hb_q      <= 1'b0;
            vb_q      <= 1'b0;
            hs_q      <= ~ACT;
            vs_q      <= ~ACT;
            sof       <= 1'b0;
            frame_cnt <= '0;
        end else if (en) begin
            h_q  <= h_nxt;
            v_q  <= v_nxt;
            hb_q <= (h_nxt >= H_VIS);
            vb_q <= (v_nxt >= V_VIS);
            hs_q <= ACT ? hs_on : ~hs_on;
            vs_q <= ACT ? vs_on : ~vs_on;
            sof  <= wrap;
            if (wrap) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end else begin
            sof <= 1'b0;
        end
    end

    assign vga_out.hcount = h_q;
    assign vga_out.vcount = v_q;
    assign vga_out.hsync  = hs_q;
    assign vga_out.vsync  = vs_q;
    assign vga_out.hblnk  = hb_q;
    assign vga_out.vblnk  = vb_q;
    assign vga_out.rgb    = 12'h000;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Random-enable bench for vga_timing_gen against a linear raster-position model,
// with small timing parameters and both sync polarities side by side.
module tb_vga_timing_gen;

    localparam int HA = 8, HF = 2, HS = 3, HB = 2;
    localparam int VA = 5, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        sof_p, sof_n;
    logic [15:0] fc_p, fc_n;

    vga_if vp ();
    vga_if vn ();

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1)
    ) u_dut_p (
        .clk(clk), .rst_n(rst_n), .en(en),
        .vga_out(vp.master), .sof(sof_p), .frame_cnt(fc_p)
    );

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(0)
    ) u_dut_n (
        .clk(clk), .rst_n(rst_n), .en(en),
        .vga_out(vn.master), .sof(sof_n), .frame_cnt(fc_n)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    int m_h, m_v, m_frame;
    bit m_sof;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (h=%0d v=%0d)",
                     tag, obs, exp, m_h, m_v);
        end
    endtask

    task automatic model_reset();
        m_h = 0;
        m_v = 0;
        m_frame = 0;
        m_sof = 0;
    endtask

    // Position as a linear pixel index within the frame.
    task automatic model_step();
        int lin;
        if (en) begin
            lin = (m_v * HT + m_h + 1) % (HT * VT);
            m_h = lin % HT;
            m_v = lin / HT;
            m_sof = (lin == 0);
            if (lin == 0) m_frame = (m_frame + 1) % 65536;
        end else begin
            m_sof = 0;
        end
    endtask

    task automatic check_all();
        bit hs, vs;
        hs = (m_h >= HA + HF) && (m_h < HA + HF + HS);
        vs = (m_v >= VA + VF) && (m_v < VA + VF + VS);
        chk("hcount", int'(vp.hcount), m_h);
        chk("vcount", int'(vp.vcount), m_v);
        chk("hblnk", int'(vp.hblnk), int'(m_h >= HA));
        chk("vblnk", int'(vp.vblnk), int'(m_v >= VA));
        chk("hsync", int'(vp.hsync), int'(hs));
        chk("vsync", int'(vp.vsync), int'(vs));
        chk("sof", int'(sof_p), int'(m_sof));
        chk("frame_cnt", int'(fc_p), m_frame);
        chk("rgb", int'(vp.rgb), 0);
        chk("hcount_n", int'(vn.hcount), m_h);
        chk("hsync_n", int'(vn.hsync), int'(!hs));
        chk("vsync_n", int'(vn.vsync), int'(!vs));
        chk("sof_n", int'(sof_n), int'(m_sof));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // Hold with en low straight out of reset: no strobe, no motion.
        repeat (4) cycle();

        en = 1'b1;
        repeat (HT * VT + 5) cycle();

        for (int i = 0; i < 4000; i++) begin
            en = ($urandom_range(0, 3) != 0);
            cycle();
            if ($urandom_range(0, 149) == 0) begin
                #2;
                rst_n = 1'b0;
                #1;
                model_reset();
                check_all();
                #1;
                rst_n = 1'b1;
            end
        end

        en = 1'b1;
        repeat (2 * HT * VT) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
